// File: rtl/matrix_traverse_pkg.sv
// rtl/matrix_traverse_pkg.sv - shared enums for the matrix traversal block
// Traversal modes, control states and spiral leg directions.
package matrix_traverse_pkg;

  typedef enum logic [1:0] {
    ROW        = 2'd0,
    COL        = 2'd1,
    SPIRAL_CW  = 2'd2,
    SPIRAL_CCW = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    L2R = 2'd0,
    U2D = 2'd1,
    R2L = 2'd2,
    D2U = 2'd3
  } leg_t;

endpackage

// File: rtl/matrix_traverse_addr_gen.sv
// rtl/matrix_traverse_addr_gen.sv - read address sequencer for one matrix bank
// rd_r/rd_c name the next element to fetch; last flags that it is the final one.
module matrix_traverse_addr_gen
  import matrix_traverse_pkg::*;
#(
  parameter int R_WIDTH = 3,
  parameter int C_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic [R_WIDTH-1:0] rows_m1,
  input  logic [C_WIDTH-1:0] cols_m1,
  input  logic [1:0]         mode,
  output logic [R_WIDTH-1:0] rd_r,
  output logic [C_WIDTH-1:0] rd_c,
  output logic               last
);

  localparam int NW = R_WIDTH + C_WIDTH + 1;

  mode_t              mode_q;
  leg_t               leg;
  logic [R_WIDTH-1:0] rows_q, top, bot;
  logic [C_WIDTH-1:0] cols_q, lft, rgt;
  logic [NW-1:0]      cnt;
  logic [NW-1:0]      total;
  logic               cw;

  assign total = (NW'(rows_m1) + NW'(1)) * (NW'(cols_m1) + NW'(1));
  assign last  = (cnt == NW'(1));
  assign cw    = (mode_q == SPIRAL_CW);

  // Leg ends hop straight onto the first element of the next leg with the
  // shrunken bound; the remaining rectangle is empty exactly when a span is,
  // so the counter always stops the walk before an empty leg is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= ROW;
      leg    <= L2R;
      rows_q <= '0;
      cols_q <= '0;
      top    <= '0;
      bot    <= '0;
      lft    <= '0;
      rgt    <= '0;
      rd_r   <= '0;
      rd_c   <= '0;
      cnt    <= '0;
    end else if (start) begin
      mode_q <= mode_t'(mode);
      leg    <= (mode_t'(mode) == SPIRAL_CCW) ? U2D : L2R;
      rows_q <= rows_m1;
      cols_q <= cols_m1;
      top    <= '0;
      bot    <= rows_m1;
      lft    <= '0;
      rgt    <= cols_m1;
      rd_r   <= '0;
      rd_c   <= '0;
      cnt    <= total;
    end else if (step) begin
      cnt <= cnt - NW'(1);
      case (mode_q)
        ROW: begin
          if (rd_c == cols_q) begin
            rd_c <= '0;
            rd_r <= rd_r + 1'b1;
          end else begin
            rd_c <= rd_c + 1'b1;
          end
        end
        COL: begin
          if (rd_r == rows_q) begin
            rd_r <= '0;
            rd_c <= rd_c + 1'b1;
          end else begin
            rd_r <= rd_r + 1'b1;
          end
        end
        default: begin
          case (leg)
            L2R, R2L: begin
              if (rd_c == ((leg == L2R) ? rgt : lft)) begin
                if ((leg == L2R) == cw) begin
                  top  <= top + 1'b1;
                  rd_r <= top + 1'b1;
                  leg  <= U2D;
                end else begin
                  bot  <= bot - 1'b1;
                  rd_r <= bot - 1'b1;
                  leg  <= D2U;
                end
              end else begin
                rd_c <= (leg == L2R) ? rd_c + 1'b1 : rd_c - 1'b1;
              end
            end
            default: begin
              if (rd_r == ((leg == U2D) ? bot : top)) begin
                if ((leg == U2D) == cw) begin
                  rgt  <= rgt - 1'b1;
                  rd_c <= rgt - 1'b1;
                  leg  <= R2L;
                end else begin
                  lft  <= lft + 1'b1;
                  rd_c <= lft + 1'b1;
                  leg  <= L2R;
                end
              end else begin
                rd_r <= (leg == U2D) ? rd_r + 1'b1 : rd_r - 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/matrix_traverse.sv
// rtl/matrix_traverse.sv - buffers a row-major matrix stream and replays it in a selected order
// MATRIX_TRAVERSE_PINGPONG_EN selects two banks with independent load and drain.
module matrix_traverse
  import matrix_traverse_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [R_WIDTH-1:0]    cfg_rows_m1,
  input  logic [C_WIDTH-1:0]    cfg_cols_m1,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int MAX_R = 2 ** R_WIDTH;
  localparam int MAX_C = 2 ** C_WIDTH;
`ifdef MATRIX_TRAVERSE_PINGPONG_EN
  localparam int   NB = 2;
  localparam logic PP = 1'b1;
`else
  localparam int   NB = 1;
  localparam logic PP = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem [NB][MAX_R][MAX_C];

  state_t                ld_state;
  logic [R_WIDTH-1:0]    wr_r, ld_rows_m1, eff_r, eff_rows, f_r;
  logic [C_WIDTH-1:0]    wr_c, ld_cols_m1, eff_c, eff_cols, f_c;
  logic                  wb, wb_nxt, rb, cand, fb;
  logic [NB-1:0]         full, full_nxt, ag_start, ag_step, ag_last;
  logic [R_WIDTH-1:0]    ag_r [NB];
  logic [C_WIDTH-1:0]    ag_c [NB];
  logic                  in_fire, first_beat, wr_done;
  logic                  out_fire, dr_end, launch, fetch, f_last;
  logic [DATA_WIDTH-1:0] f_data;

  assign in_fire    = in_valid && in_ready;
  assign first_beat = in_fire && (ld_state == IDLE);
  assign eff_rows   = first_beat ? cfg_rows_m1 : ld_rows_m1;
  assign eff_cols   = first_beat ? cfg_cols_m1 : ld_cols_m1;
  assign eff_r      = first_beat ? '0 : wr_r;
  assign eff_c      = first_beat ? '0 : wr_c;
  assign wr_done    = in_fire && (eff_r == eff_rows) && (eff_c == eff_cols);

  // A bank becomes drainable on the same edge its last element lands, which
  // gives one-cycle latency and lets the next bank follow with no bubble.
  assign out_fire = out_valid && out_ready;
  assign dr_end   = out_fire && out_last;
  assign cand     = out_valid ? (rb ^ PP) : rb;
  assign launch   = (!out_valid || dr_end) &&
                    ((full[cand] && !(out_valid && (cand == rb))) || (wr_done && (wb == cand)));
  assign fetch    = launch || (out_fire && !out_last);
  assign fb       = launch ? cand : rb;
  assign f_r      = launch ? '0 : ag_r[fb];
  assign f_c      = launch ? '0 : ag_c[fb];
  assign f_last   = (launch && first_beat && (wb == cand)) ? 1'b1 : ag_last[fb];
  assign f_data   = (in_fire && (wb == fb) && (eff_r == f_r) && (eff_c == f_c)) ?
                    in_data : mem[fb][f_r][f_c];

  assign busy = (ld_state != IDLE) || (|full) || out_valid;

  always_comb begin
    full_nxt = full;
    if (dr_end)  full_nxt[rb] = 1'b0;
    if (wr_done) full_nxt[wb] = 1'b1;
    wb_nxt = wr_done ? (wb ^ PP) : wb;
    for (int b = 0; b < NB; b++) begin
      ag_start[b] = first_beat && (wb == b[0]);
      ag_step[b]  = fetch && (fb == b[0]);
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    matrix_traverse_addr_gen #(
      .R_WIDTH (R_WIDTH),
      .C_WIDTH (C_WIDTH)
    ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .start   (ag_start[b]),
      .step    (ag_step[b]),
      .rows_m1 (cfg_rows_m1),
      .cols_m1 (cfg_cols_m1),
      .mode    (cfg_mode),
      .rd_r    (ag_r[b]),
      .rd_c    (ag_c[b]),
      .last    (ag_last[b])
    );
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[wb][eff_r][eff_c] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state   <= IDLE;
      wr_r       <= '0;
      wr_c       <= '0;
      ld_rows_m1 <= '0;
      ld_cols_m1 <= '0;
      wb         <= 1'b0;
      full       <= '0;
      in_ready   <= 1'b0;
    end else begin
      full     <= full_nxt;
      wb       <= wb_nxt;
      in_ready <= !full_nxt[wb_nxt];
      case (ld_state)
        IDLE, LOAD: begin
          if (in_fire) begin
            if (ld_state == IDLE) begin
              ld_rows_m1 <= cfg_rows_m1;
              ld_cols_m1 <= cfg_cols_m1;
            end
            if (wr_done) begin
              wr_r     <= '0;
              wr_c     <= '0;
              ld_state <= PP ? IDLE : DRAIN;
            end else begin
              ld_state <= LOAD;
              if (eff_c == eff_cols) begin
                wr_c <= '0;
                wr_r <= eff_r + 1'b1;
              end else begin
                wr_c <= eff_c + 1'b1;
                wr_r <= eff_r;
              end
            end
          end
        end
        DRAIN:   if (dr_end) ld_state <= IDLE;
        default: ld_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      rb        <= 1'b0;
    end else if (fetch) begin
      out_valid <= 1'b1;
      out_data  <= f_data;
      out_last  <= f_last;
      rb        <= fb;
    end else if (dr_end) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      rb        <= rb ^ PP;
    end
  end

endmodule

// File: tb/tb_matrix_traverse.sv
// tb/tb_matrix_traverse.sv - directed self-checking bench for matrix_traverse
module tb_matrix_traverse;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cfg_rows_m1, cfg_cols_m1;
  logic [1:0] cfg_mode;
  logic [7:0] in_data, out_data;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, busy;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int w, w2, gaps;

  always #5 clk = ~clk;

  matrix_traverse #(.DATA_WIDTH(8), .R_WIDTH(3), .C_WIDTH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_rows_m1 (cfg_rows_m1),
    .cfg_cols_m1 (cfg_cols_m1),
    .cfg_mode    (cfg_mode),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send(input int rm1, input int cm1, input int md, input int base, input int n,
                      output int waits);
    int g;
    cfg_rows_m1 = 3'(rm1);
    cfg_cols_m1 = 3'(cm1);
    cfg_mode    = 2'(md);
    waits = 0;
    for (int i = 0; i < n; i++) begin
      in_data  = 8'(base + i);
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 200) begin
        @(negedge clk);
        g++;
        waits++;
      end
      if (!in_ready) check("in_ready_wait", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input bit stall, output int gap_cnt);
    int k, g;
    bit held, rdy;
    logic [7:0] hd;
    logic hl;
    k = 0; g = 0; held = 0; gap_cnt = 0;
    while (k < exp_q.size() && g < 3000) begin
      if (out_valid) begin
        if (held) begin
          check("hold_data", out_data, hd);
          check("hold_last", out_last, hl);
        end
        rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = rdy;
        if (rdy) begin
          check($sformatf("data[%0d]", k), out_data, exp_q[k]);
          check($sformatf("last[%0d]", k), out_last, 32'(k == exp_q.size() - 1));
          k++;
          held = 0;
        end else begin
          held = 1;
          hd = out_data;
          hl = out_last;
        end
      end else begin
        out_ready = 1'b1;
        if (k > 0) gap_cnt++;
      end
      @(negedge clk);
      g++;
    end
    out_ready = 1'b0;
    check("collect_count", k, exp_q.size());
  endtask

  // Independent spiral reference: walk and turn on wall or visited cell.
  task automatic spiral_ref(input int rows, input int cols, input bit cw);
    bit vis [8][8];
    int dr [4], dc [4];
    int r, c, d, nr, nc;
    if (cw) begin dr = '{0, 1, 0, -1}; dc = '{1, 0, -1, 0}; end
    else    begin dr = '{1, 0, -1, 0}; dc = '{0, 1, 0, -1}; end
    for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) vis[i][j] = 0;
    exp_q.delete();
    r = 0; c = 0; d = 0;
    for (int n = 0; n < rows * cols; n++) begin
      exp_q.push_back(r * cols + c + 1);
      vis[r][c] = 1;
      nr = r + dr[d]; nc = c + dc[d];
      if (nr < 0 || nr >= rows || nc < 0 || nc >= cols || vis[nr][nc]) begin
        d = (d + 1) % 4;
        nr = r + dr[d]; nc = c + dc[d];
      end
      r = nr; c = nc;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_rows_m1 = '0; cfg_cols_m1 = '0; cfg_mode = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    exp_q = '{1, 2, 3, 6, 9, 8, 7, 4, 5};
    send(2, 2, 2, 1, 9, w);
    check("latency_out_valid", out_valid, 1);
    check("busy_drain", busy, 1);
`ifndef MATRIX_TRAVERSE_PINGPONG_EN
    check("in_ready_drain", in_ready, 0);
`endif
    collect(0, gaps);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);

    exp_q = '{1, 2, 3, 4, 8, 12, 11, 10, 9, 5, 6, 7};
    send(2, 3, 2, 1, 12, w);
    collect(0, gaps);
    exp_q = '{1, 5, 9, 10, 11, 12, 8, 4, 3, 2, 6, 7};
    send(2, 3, 3, 1, 12, w);
    collect(0, gaps);

    exp_q = '{1, 4, 2, 5, 3, 6};
    send(1, 2, 1, 1, 6, w);
    collect(0, gaps);

    exp_q = '{1, 2, 3, 4};
    send(0, 3, 2, 1, 4, w);
    collect(0, gaps);
    send(3, 0, 2, 1, 4, w);
    collect(0, gaps);

    exp_q = '{42};
    send(0, 0, 0, 42, 1, w);
    check("1x1_out_valid", out_valid, 1);
    check("1x1_out_last", out_last, 1);
    collect(0, gaps);

    spiral_ref(8, 8, 1'b1);
    send(7, 7, 2, 1, 64, w);
    collect(1, gaps);

    send(2, 2, 2, 1, 4, w);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    exp_q = '{5, 6, 7, 8};
    send(1, 1, 0, 5, 4, w);
    collect(0, gaps);
    repeat (3) @(negedge clk);
    check("no_trailing_output", out_valid, 0);

`ifdef MATRIX_TRAVERSE_PINGPONG_EN
    exp_q = '{1, 2, 3, 6, 9, 8, 7, 4, 5, 11, 12, 13, 16, 19, 18, 17, 14, 15};
    fork
      begin
        send(2, 2, 2, 1, 9, w);
        send(2, 2, 2, 11, 9, w2);
      end
      collect(0, gaps);
    join
    check("pp_output_gaps", gaps, 0);
    check("pp_second_load_waits", w2, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
